bcd_subtractor_seq: RTL

- Digit-serial, multi-digit BCD subtractor. It is the subtract-direction companion of the team's 3-digit ripple BCD adder.
- Computes Diff = (A - B - Bin) mod 10^DIGITS and a borrow-out, one BCD digit per clock, least significant digit first.
- Sits beside the adder in the calculator datapath. A start/busy/done handshake lets a controller FSM sequence operations.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_subtractor_seq_if.sv | 45 ++++
 rtl/bcd_sub_digit.sv | 41 ++++
 rtl/bcd_subtractor_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared definitions for the digit-serial BCD subtractor.
//               Holds the BCD digit geometry, the controller state encoding
//               and a nibble validity helper used when operands are captured.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int DIGIT_W   = 4;
  localparam int BCD_MAX   = 9;
  localparam int BCD_RADIX = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // A nibble is a legal BCD digit only in the range 0..9.
  function automatic logic nibble_valid(input logic [DIGIT_W-1:0] n);
    return (n <= DIGIT_W'(BCD_MAX));
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_subtractor_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_subtractor_seq_if
// Description : Operand/result bundle between a sequencing controller and
//               the digit-serial BCD subtractor.
// Signals     : start       - operation request (controller -> subtractor)
//               A, B        - packed BCD minuend / subtrahend
//               Bin         - borrow-in
//               busy        - operation in flight
//               done        - one-cycle result-update pulse
//               Diff        - packed BCD difference
//               Bout        - borrow-out
//               err         - a captured nibble was not a BCD digit
// Modports    : master (controller side), slave (subtractor side)
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_subtractor_seq_if #(
  parameter int DIGITS = 3
) ();
  import bcd_pkg::*;

  localparam int W = DIGIT_W * DIGITS;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         err;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Bout, err
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Bout, err
  );

endinterface
`default_nettype wire

// File: rtl/bcd_sub_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_sub_digit
// Description : Single-digit combinational BCD subtract cell. Computes
//               a - b - bin; a negative intermediate is corrected by adding
//               the radix and reported as a borrow.
// Ports       : a    [3:0] in  - minuend digit
//               b    [3:0] in  - subtrahend digit
//               bin        in  - borrow from the less significant digit
//               d    [3:0] out - difference digit
//               bout       out - borrow to the more significant digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_sub_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  // Five signed bits span every a - b - bin outcome for 4-bit inputs
  // (-16 .. 15), so no intermediate overflows.
  logic signed [DIGIT_W:0] t;
  logic signed [DIGIT_W:0] t_adj;

  always_comb begin
    t     = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({{DIGIT_W{1'b0}}, bin});
    t_adj = t + (DIGIT_W+1)'(BCD_RADIX);
    d     = t[DIGIT_W-1:0];
    bout  = 1'b0;
    if (t < 0) begin
      d    = t_adj[DIGIT_W-1:0];
      bout = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_subtractor_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_subtractor_seq
// Description : Digit-serial multi-digit BCD subtractor. Computes
//               Diff = (A - B - Bin) mod 10^DIGITS and a borrow-out, one
//               digit per clock, least significant digit first, reusing a
//               single bcd_sub_digit cell.
// Ports       : clk    in  - system clock, rising edge
//               rst_n  in  - asynchronous active-low reset
//               bus    slave modport of bcd_subtractor_seq_if
//                        start/A/B/Bin in, busy/done/Diff/Bout/err out
// Timing      : start sampled in IDLE at edge k, digits at edges k+1..
//               k+DIGITS, done pulse and result update at edge k+DIGITS+1,
//               back in IDLE at edge k+DIGITS+2.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_subtractor_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_subtractor_seq_if.slave  bus
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = $clog2(DIGITS + 1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;       // remaining minuend digits, LSD at [3:0]
  logic [W-1:0]       b_q, b_d;       // remaining subtrahend digits
  logic               br_q, br_d;     // running borrow between digits
  logic [IDX_W-1:0]   idx_q, idx_d;   // digit being processed
  logic               inval_q, inval_d;
  logic [W-1:0]       work_q, work_d; // partial result, filled from the top
  logic [W-1:0]       diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  // --------------------------------------------------------------------------
  // Operand validity, evaluated on the live bus and captured with the data
  // --------------------------------------------------------------------------
  logic [DIGITS-1:0]  nib_ok;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib_chk
    assign nib_ok[gi] = nibble_valid(bus.A[gi*DIGIT_W +: DIGIT_W]) &&
                        nibble_valid(bus.B[gi*DIGIT_W +: DIGIT_W]);
  end

  // --------------------------------------------------------------------------
  // The shared per-digit cell always works on the low nibble; operands are
  // shifted down one digit per CALC cycle.
  // --------------------------------------------------------------------------
  logic [DIGIT_W-1:0] cell_d;
  logic               cell_bout;

  bcd_sub_digit u_digit (
    .a    (a_q[DIGIT_W-1:0]),
    .b    (b_q[DIGIT_W-1:0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    idx_d   = idx_q;
    inval_d = inval_q;
    work_d  = work_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          br_d    = bus.Bin;
          inval_d = ~&nib_ok;
          idx_d   = '0;
          work_d  = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        // New digit enters at the top; after DIGITS shifts digit 0 sits
        // in [3:0].
        work_d = {cell_d, work_q[W-1:DIGIT_W]};
        a_d    = a_q >> DIGIT_W;
        b_d    = b_q >> DIGIT_W;
        br_d   = cell_bout;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // DONE spans two cycles: the first publishes the result and raises
        // done, the second lets done fall before returning to IDLE, so a
        // held start is not re-sampled until the pulse has completed.
        if (!done_q) begin
          done_d = 1'b1;
          err_d  = inval_q;
          diff_d = inval_q ? '0   : work_q;
          bout_d = inval_q ? 1'b0 : br_q;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // busy rises on the first digit edge and falls as IDLE is re-entered.
    busy_d = (state_d != IDLE) && (state_q != IDLE);
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      idx_q   <= '0;
      inval_q <= 1'b0;
      work_q  <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      idx_q   <= idx_d;
      inval_q <= inval_d;
      work_q  <= work_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
  assign bus.err  = err_q;

endmodule
`default_nettype wire
